flash_word_fetcher: RTL

- Upstream stage of the audio playback FSM.
- Watches the word address requested by the FSM and performs one Avalon-MM read on the flash controller per address change.
- Holds the returned 32-bit word stable on word_out, which drives the FSM's flash_mem_readdata input.
- Runs on the fast system clock; the FSM's sample clock is much slower, so the fetch completes well within one sample period.

---
 rtl/flash_word_fetcher.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/flash_word_fetcher.sv
// Fetches one 32-bit word from the flash controller (Avalon-MM) per change of
// the requested word address, and holds it stable for the playback FSM.
module flash_word_fetcher #(
   parameter int ADDR_W         = 23,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [ADDR_W-1:0] req_address,
   output logic              flash_mem_read,
   output logic [ADDR_W-1:0] flash_mem_address,
   output logic [3:0]        flash_mem_byteenable,
   input  logic              flash_mem_waitrequest,
   input  logic [DATA_W-1:0] flash_mem_readdata,
   input  logic              flash_mem_readdatavalid,
   output logic [DATA_W-1:0] word_out,
   output logic              word_valid,
   output logic              busy,
   output logic              timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DATA = 2'd2,
      ST_CHECK     = 2'd3
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t              state_r, state_nxt_s;
   logic [ADDR_W-1:0]   req_meta_r, req_q_r;
   logic [ADDR_W-1:0]   last_addr_r, last_addr_nxt_s;
   logic [ADDR_W-1:0]   fetch_addr_r, fetch_addr_nxt_s;
   logic                first_done_r, first_done_nxt_s;
   logic [7:0]          tmo_cnt_r, tmo_cnt_nxt_s;
   logic                read_nxt_s;
   logic [ADDR_W-1:0]   address_nxt_s;
   logic [DATA_W-1:0]   word_nxt_s;
   logic                word_valid_nxt_s;
   logic                busy_nxt_s;
   logic                timeout_err_nxt_s;
   logic                fetch_needed_s;

   assign flash_mem_byteenable = 4'b1111;
   assign fetch_needed_s = enable & (~first_done_r | (req_q_r != last_addr_r));

   // Two-flop register stage on the requested address.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_meta_r <= '0;
         req_q_r    <= '0;
      end else begin
         req_meta_r <= req_address;
         req_q_r    <= req_meta_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt_s       = state_r;
      last_addr_nxt_s   = last_addr_r;
      fetch_addr_nxt_s  = fetch_addr_r;
      first_done_nxt_s  = first_done_r;
      tmo_cnt_nxt_s     = tmo_cnt_r;
      read_nxt_s        = flash_mem_read;
      address_nxt_s     = flash_mem_address;
      word_nxt_s        = word_out;
      word_valid_nxt_s  = word_valid;
      timeout_err_nxt_s = timeout_err;
      case (state_r)
         ST_IDLE: begin
            if (fetch_needed_s) begin
               fetch_addr_nxt_s = req_q_r;
               address_nxt_s    = req_q_r;
               read_nxt_s       = 1'b1;
               word_valid_nxt_s = 1'b0;
               state_nxt_s      = ST_ISSUE;
            end else begin
               read_nxt_s  = 1'b0;
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (!flash_mem_waitrequest) begin
               read_nxt_s    = 1'b0;
               tmo_cnt_nxt_s = 8'd0;
               state_nxt_s   = ST_WAIT_DATA;
            end else begin
               read_nxt_s  = 1'b1;
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_WAIT_DATA: begin
            // Data is checked before the terminal count so a simultaneous
            // arrival is accepted rather than flagged.
            if (flash_mem_readdatavalid) begin
               word_nxt_s       = flash_mem_readdata;
               last_addr_nxt_s  = fetch_addr_r;
               first_done_nxt_s = 1'b1;
               state_nxt_s      = ST_CHECK;
            end else if (tmo_cnt_r == TMO_LAST) begin
               timeout_err_nxt_s = 1'b1;
               last_addr_nxt_s   = fetch_addr_r;
               first_done_nxt_s  = 1'b1;
               state_nxt_s       = ST_IDLE;
            end else begin
               tmo_cnt_nxt_s = tmo_cnt_r + 8'd1;
               state_nxt_s   = ST_WAIT_DATA;
            end
         end
         ST_CHECK: begin
            word_valid_nxt_s = (req_q_r == fetch_addr_r);
            state_nxt_s      = ST_IDLE;
         end
         default: begin
            read_nxt_s  = 1'b0;
            state_nxt_s = ST_IDLE;
         end
      endcase
      busy_nxt_s = (state_nxt_s != ST_IDLE);
   end

   // Registered outputs and datapath state.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_addr_r       <= '0;
         fetch_addr_r      <= '0;
         first_done_r      <= 1'b0;
         tmo_cnt_r         <= 8'd0;
         flash_mem_read    <= 1'b0;
         flash_mem_address <= '0;
         word_out          <= '0;
         word_valid        <= 1'b0;
         busy              <= 1'b0;
         timeout_err       <= 1'b0;
      end else begin
         last_addr_r       <= last_addr_nxt_s;
         fetch_addr_r      <= fetch_addr_nxt_s;
         first_done_r      <= first_done_nxt_s;
         tmo_cnt_r         <= tmo_cnt_nxt_s;
         flash_mem_read    <= read_nxt_s;
         flash_mem_address <= address_nxt_s;
         word_out          <= word_nxt_s;
         word_valid        <= word_valid_nxt_s;
         busy              <= busy_nxt_s;
         timeout_err       <= timeout_err_nxt_s;
      end
   end

endmodule
